// File: rtl/chess_cursor_ctrl.sv
// Board cursor and two-step source/destination select that issues move requests over valid/ready.
// Define CHESS_CURSOR_WRAP_EN to wrap the cursor modulo 8; otherwise it saturates at the board edges.
module chess_cursor_ctrl #(
   parameter int unsigned CURSOR_X_INIT = 4,
   parameter int unsigned CURSOR_Y_INIT = 1,
   parameter int unsigned SEL_TIMEOUT   = 0
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       btn_l_pulse,
   input  logic       btn_r_pulse,
   input  logic       btn_u_pulse,
   input  logic       btn_d_pulse,
   input  logic       btn_c_pulse,
   output logic [2:0] cursor_x,
   output logic [2:0] cursor_y,
   output logic       sel_valid,
   output logic [5:0] sel_sq,
   output logic       move_valid,
   output logic [5:0] move_src,
   output logic [5:0] move_dst,
   input  logic       move_ready,
   output logic       side_to_move
);

   typedef enum logic [1:0] {
      SEL_SRC   = 2'd0,
      SEL_DST   = 2'd1,
      MOVE_PEND = 2'd2
   } state_t;

   // Counter never exceeds SEL_TIMEOUT-2, so clog2(SEL_TIMEOUT) bits are enough.
   localparam int CNT_W = (SEL_TIMEOUT > 2) ? $clog2(SEL_TIMEOUT) : 1;
   localparam logic [1:0][2:0] POS_INIT = {3'(CURSOR_Y_INIT), 3'(CURSOR_X_INIT)};

   state_t           state_reg, state_next;
   logic [1:0][2:0]  pos_reg, pos_next, pos_step;
   logic [1:0]       inc, dec;
   logic             sel_valid_reg, sel_valid_next;
   logic [5:0]       sel_sq_reg, sel_sq_next;
   logic             move_valid_reg, move_valid_next;
   logic [5:0]       move_src_reg, move_src_next;
   logic [5:0]       move_dst_reg, move_dst_next;
   logic             side_reg, side_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [5:0]       cur_sq;
   logic             any_pulse;

   // Axis 0 is the file (x), axis 1 the rank (y).
   assign inc = {btn_u_pulse, btn_r_pulse};
   assign dec = {btn_d_pulse, btn_l_pulse};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_axis
         logic up, dn;
         assign up = inc[gi] & ~dec[gi];
         assign dn = dec[gi] & ~inc[gi];
`ifdef CHESS_CURSOR_WRAP_EN
         assign pos_step[gi] = up ? pos_reg[gi] + 3'd1 :
                               dn ? pos_reg[gi] - 3'd1 : pos_reg[gi];
`else
         assign pos_step[gi] = (up && pos_reg[gi] != 3'd7) ? pos_reg[gi] + 3'd1 :
                               (dn && pos_reg[gi] != 3'd0) ? pos_reg[gi] - 3'd1 : pos_reg[gi];
`endif
      end
   endgenerate

   assign cur_sq    = {pos_reg[1], pos_reg[0]};
   assign any_pulse = btn_l_pulse | btn_r_pulse | btn_u_pulse | btn_d_pulse | btn_c_pulse;

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_reg      <= SEL_SRC;
         pos_reg        <= POS_INIT;
         sel_valid_reg  <= 1'b0;
         sel_sq_reg     <= '0;
         move_valid_reg <= 1'b0;
         move_src_reg   <= '0;
         move_dst_reg   <= '0;
         side_reg       <= 1'b0;
         cnt_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         pos_reg        <= pos_next;
         sel_valid_reg  <= sel_valid_next;
         sel_sq_reg     <= sel_sq_next;
         move_valid_reg <= move_valid_next;
         move_src_reg   <= move_src_next;
         move_dst_reg   <= move_dst_next;
         side_reg       <= side_next;
         cnt_reg        <= cnt_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      pos_next        = pos_reg;
      sel_valid_next  = sel_valid_reg;
      sel_sq_next     = sel_sq_reg;
      move_valid_next = move_valid_reg;
      move_src_next   = move_src_reg;
      move_dst_next   = move_dst_reg;
      side_next       = side_reg;
      cnt_next        = cnt_reg;

      unique case (state_reg)
         SEL_SRC: begin
            pos_next = pos_step;
            cnt_next = '0;
            // The held square is the pre-move cursor even if a direction pulse coincides.
            if (btn_c_pulse) begin
               sel_sq_next    = cur_sq;
               sel_valid_next = 1'b1;
               state_next     = SEL_DST;
            end
         end
         SEL_DST: begin
            pos_next = pos_step;
            if (btn_c_pulse) begin
               cnt_next = '0;
               if (cur_sq == sel_sq_reg) begin
                  sel_valid_next = 1'b0;
                  state_next     = SEL_SRC;
               end else begin
                  move_src_next   = sel_sq_reg;
                  move_dst_next   = cur_sq;
                  move_valid_next = 1'b1;
                  state_next      = MOVE_PEND;
               end
            end else if (any_pulse) begin
               cnt_next = '0;
            end else if (SEL_TIMEOUT != 0) begin
               // Cancel on the idle cycle that brings the count to SEL_TIMEOUT-1.
               if (32'(cnt_reg) + 32'd2 >= SEL_TIMEOUT) begin
                  sel_valid_next = 1'b0;
                  cnt_next       = '0;
                  state_next     = SEL_SRC;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end
         MOVE_PEND: begin
            if (move_valid_reg && move_ready) begin
               move_valid_next = 1'b0;
               sel_valid_next  = 1'b0;
               side_next       = ~side_reg;
               state_next      = SEL_SRC;
            end
         end
         default: state_next = SEL_SRC;
      endcase
   end

   assign cursor_x     = pos_reg[0];
   assign cursor_y     = pos_reg[1];
   assign sel_valid    = sel_valid_reg;
   assign sel_sq       = sel_sq_reg;
   assign move_valid   = move_valid_reg;
   assign move_src     = move_src_reg;
   assign move_dst     = move_dst_reg;
   assign side_to_move = side_reg;

endmodule

// File: tb/tb_chess_cursor_ctrl.sv
// Directed bench for chess_cursor_ctrl: per-cycle state snapshots and accepted moves are
// queued by the stimulus and checked by independent monitor processes.
module tb_chess_cursor_ctrl;

   localparam logic [4:0] BN = 5'b00000;
   localparam logic [4:0] BL = 5'b00001;
   localparam logic [4:0] BR = 5'b00010;
   localparam logic [4:0] BU = 5'b00100;
   localparam logic [4:0] BD = 5'b01000;
   localparam logic [4:0] BC = 5'b10000;

   logic       clk;
   logic       Reset;
   logic       btn_l_pulse, btn_r_pulse, btn_u_pulse, btn_d_pulse, btn_c_pulse;
   logic [2:0] cursor_x, cursor_y;
   logic       sel_valid;
   logic [5:0] sel_sq;
   logic       move_valid;
   logic [5:0] move_src, move_dst;
   logic       move_ready;
   logic       side_to_move;

   chess_cursor_ctrl #(
      .CURSOR_X_INIT(4),
      .CURSOR_Y_INIT(1),
      .SEL_TIMEOUT  (10)
   ) dut (
      .clk         (clk),
      .Reset       (Reset),
      .btn_l_pulse (btn_l_pulse),
      .btn_r_pulse (btn_r_pulse),
      .btn_u_pulse (btn_u_pulse),
      .btn_d_pulse (btn_d_pulse),
      .btn_c_pulse (btn_c_pulse),
      .cursor_x    (cursor_x),
      .cursor_y    (cursor_y),
      .sel_valid   (sel_valid),
      .sel_sq      (sel_sq),
      .move_valid  (move_valid),
      .move_src    (move_src),
      .move_dst    (move_dst),
      .move_ready  (move_ready),
      .side_to_move(side_to_move)
   );

   typedef struct {
      int         cyc;
      string      name;
      logic [2:0] x, y;
      logic       sv;
      logic [5:0] sq;
      logic       mv;
      logic [5:0] src, dst;
      logic       side;
   } snap_t;

   typedef struct {
      logic [5:0] src, dst;
      logic       side;
   } move_t;

   snap_t snap_q[$];
   move_t move_q[$];
   int    cyc   = 0;
   int    total = 0;
   int    bad   = 0;

   logic [2:0] ex, ey;
   logic       esv, emv, eside;
   logic [5:0] esq, esrc, edst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   task automatic step(input logic [4:0] b, input logic rdy, input logic rst);
      @(negedge clk);
      {btn_c_pulse, btn_d_pulse, btn_u_pulse, btn_r_pulse, btn_l_pulse} = b;
      move_ready = rdy;
      Reset      = rst;
      @(posedge clk);
      cyc++;
   endtask

   task automatic exp_reset();
      ex = 3'd4; ey = 3'd1; esv = 1'b0; esq = 6'd0;
      emv = 1'b0; esrc = 6'd0; edst = 6'd0; eside = 1'b0;
   endtask

   task automatic chk(input string name);
      snap_t s;
      s.cyc = cyc; s.name = name; s.x = ex; s.y = ey; s.sv = esv; s.sq = esq;
      s.mv = emv; s.src = esrc; s.dst = edst; s.side = eside;
      snap_q.push_back(s);
   endtask

   task automatic push_move(input logic [5:0] src, input logic [5:0] dst, input logic side);
      move_t m;
      m.src = src; m.dst = dst; m.side = side;
      move_q.push_back(m);
   endtask

   // State monitor: settled outputs after each edge against queued snapshots.
   initial begin
      snap_t e;
      forever begin
         @(posedge clk);
         #2;
         while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            e = snap_q.pop_front();
            total++;
            if ({cursor_x, cursor_y, sel_valid, sel_sq, move_valid, move_src, move_dst, side_to_move} !==
                {e.x, e.y, e.sv, e.sq, e.mv, e.src, e.dst, e.side}) begin
               bad++;
               $display("FAIL %s cyc=%0d got x=%0d y=%0d sv=%0d sq=%0d mv=%0d src=%0d dst=%0d side=%0d want x=%0d y=%0d sv=%0d sq=%0d mv=%0d src=%0d dst=%0d side=%0d",
                        e.name, e.cyc, cursor_x, cursor_y, sel_valid, sel_sq, move_valid, move_src,
                        move_dst, side_to_move, e.x, e.y, e.sv, e.sq, e.mv, e.src, e.dst, e.side);
            end
         end
      end
   end

   // Handshake monitor: every move that will be accepted at the next edge.
   initial begin
      move_t m;
      forever begin
         @(negedge clk);
         #2;
         if (move_valid && move_ready && !Reset) begin
            total++;
            if (move_q.size() == 0) begin
               bad++;
               $display("FAIL move_unexpected got src=%0d dst=%0d side=%0d want none",
                        move_src, move_dst, side_to_move);
            end else begin
               m = move_q.pop_front();
               if ({move_src, move_dst, side_to_move} !== {m.src, m.dst, m.side}) begin
                  bad++;
                  $display("FAIL move_accept got src=%0d dst=%0d side=%0d want src=%0d dst=%0d side=%0d",
                           move_src, move_dst, side_to_move, m.src, m.dst, m.side);
               end else begin
                  $display("move accepted src=%0d dst=%0d side=%0d", move_src, move_dst, side_to_move);
               end
            end
         end
      end
   end

   initial begin
      {btn_c_pulse, btn_d_pulse, btn_u_pulse, btn_r_pulse, btn_l_pulse} = BN;
      move_ready = 1'b0;
      Reset      = 1'b1;
      exp_reset();

      step(BN, 0, 1); step(BN, 0, 1); chk("reset");
      step(BR, 0, 0); ex = 3'd5; chk("r1");
      step(BR, 0, 0); step(BR, 0, 0); ex = 3'd7; chk("r3");
      step(BU, 0, 0); step(BU, 0, 0); ey = 3'd3; chk("r3u2");
      step(BR, 0, 0);
`ifdef CHESS_CURSOR_WRAP_EN
      ex = 3'd0;
`endif
      chk("edge_r");
      step(BD, 0, 0); step(BD, 0, 0); step(BD, 0, 0); ey = 3'd0; chk("d3");
      step(BD, 0, 0);
`ifdef CHESS_CURSOR_WRAP_EN
      ey = 3'd7;
`endif
      chk("edge_d");
      step(BN, 0, 1); exp_reset(); chk("reset2");
      step(BN, 0, 0);
      repeat (4) step(BL, 0, 0);
      ex = 3'd0; chk("l4");
      step(BL, 0, 0);
`ifdef CHESS_CURSOR_WRAP_EN
      ex = 3'd7;
`endif
      chk("edge_l");
      step(BN, 0, 1); exp_reset(); chk("reset3");
      step(BN, 0, 0);

      // Full move e2-e4 with a stalled handshake.
      step(BC, 0, 0); esv = 1'b1; esq = 6'd12; chk("sel_src");
      step(BU, 0, 0); ey = 3'd2; chk("dst_u1");
      step(BU, 0, 0); ey = 3'd3; chk("dst_u2");
      step(BC, 0, 0); emv = 1'b1; esrc = 6'd12; edst = 6'd28; push_move(6'd12, 6'd28, 1'b0);
      chk("move_issue");
      for (int i = 0; i < 5; i++) begin
         step((i == 2) ? (BL | BC) : BL, 0, 0); chk("pend_hold");
      end
      step(BN, 1, 0); emv = 1'b0; esv = 1'b0; eside = 1'b1; chk("accept");
      step(BN, 1, 0); chk("ready_idle");

      // Select then cancel on the same square, twice.
      step(BC, 0, 0); esv = 1'b1; esq = 6'd28; chk("sel_again");
      step(BC, 0, 0); esv = 1'b0; chk("cancel");
      step(BC, 0, 0); esv = 1'b1; chk("resel");
      step(BC, 0, 0); esv = 1'b0; chk("cancel2");

      // Simultaneous pulses.
      step(BL | BR | BU, 0, 0); ey = 3'd4; chk("lr_u");
      step(BL | BD, 0, 0); ex = 3'd3; ey = 3'd3;
      step(BL | BD, 0, 0); ex = 3'd2; ey = 3'd2; chk("to_22");
      step(BU | BD, 0, 0); chk("ud");
      step(BC | BR, 0, 0); esv = 1'b1; esq = 6'd18; ex = 3'd3; chk("c_with_r");

      // Timeout after 9 idle cycles.
      repeat (8) step(BN, 0, 0);
      chk("to_hold");
      step(BN, 0, 0); esv = 1'b0; chk("timeout");

      // A pulse mid-wait restarts the count.
      step(BC, 0, 0); esv = 1'b1; esq = 6'd19; chk("sel_19");
      repeat (4) step(BN, 0, 0);
      step(BU, 0, 0); ey = 3'd3;
      repeat (8) step(BN, 0, 0);
      chk("restart_hold");
      step(BN, 0, 0); esv = 1'b0; chk("restart_timeout");

      // Reset while a move is pending, with ready asserted in the same cycle.
      step(BC, 0, 0); esv = 1'b1; esq = 6'd27;
      step(BR, 0, 0); ex = 3'd4;
      step(BC, 0, 0); emv = 1'b1; esrc = 6'd27; edst = 6'd28; chk("move3");
      step(BN, 1, 1); exp_reset(); chk("reset_mid");
      step(BN, 0, 0); chk("post_reset");

      // A move after reset is accepted as white's.
      step(BC, 0, 0); esv = 1'b1; esq = 6'd12;
      step(BR, 0, 0); ex = 3'd5;
      step(BC, 0, 0); emv = 1'b1; esrc = 6'd12; edst = 6'd13; push_move(6'd12, 6'd13, 1'b0);
      chk("move2");
      step(BN, 1, 0); emv = 1'b0; esv = 1'b0; eside = 1'b1; chk("accept2");

      step(BN, 0, 0); step(BN, 0, 0);
      total++;
      if (snap_q.size() != 0 || move_q.size() != 0) begin
         bad++;
         $display("FAIL drain got snaps=%0d moves=%0d left want 0 and 0", snap_q.size(), move_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
